uart_report_tx: RTL and testbench

- Transmit-side formatter for the UART link.
- On a request, it latches a 16-bit display value and a tag character. It serialises them as an ASCII frame, byte by byte, into the UART TX FIFO push interface.
- It sits between the stopwatch/watch/sensor display mux and the UART TX FIFO. It is the counterpart of the RX command decoder that produces cmd_tick/cmd_switch.

---
 rtl/uart_rpt_pkg.sv | 30 +++
 rtl/nibble_to_ascii.sv | 11 +
 rtl/uart_report_tx.sv | 126 ++++++++++++
 tb/tb_uart_report_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rpt_pkg.sv
// Shared constants, state type and frame-length helpers for the UART report formatter.
// The frame grows by two checksum digits when UART_RPT_CHECKSUM_EN is defined.
package uart_rpt_pkg;

    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

`ifdef UART_RPT_CHECKSUM_EN
    localparam int CHK_BYTES = 2;
`else
    localparam int CHK_BYTES = 0;
`endif

    // Tag, colon and four digits, plus the optional checksum digits, precede the EOL.
    localparam int BODY_LEN       = 6 + CHK_BYTES;
    localparam int FRAME_LEN_CRLF = BODY_LEN + 2;
    localparam int FRAME_LEN_LF   = BODY_LEN + 1;

    function automatic int frame_len(input bit eol_crlf);
        return eol_crlf ? FRAME_LEN_CRLF : FRAME_LEN_LF;
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex character converter.
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    end

endmodule

// File: rtl/uart_report_tx.sv
// Formats a latched tag and 16-bit value as an ASCII hex frame and pushes it into the UART TX FIFO.
// Optional macro UART_RPT_CHECKSUM_EN inserts two XOR-checksum hex digits before the EOL.
module uart_report_tx
    import uart_rpt_pkg::*;
#(
    parameter int EOL_CRLF = 1,
    parameter int HOLDOFF  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [7:0]  i_tag,
    input  logic [15:0] i_data,
    input  logic        i_tx_full,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_push,
    output logic        o_busy,
    output logic        o_done
);

    localparam int          FRAME_LEN   = frame_len(EOL_CRLF != 0);
    localparam logic [3:0]  LAST_IDX    = 4'(FRAME_LEN - 1);
    localparam logic [3:0]  EOL_IDX     = 4'(BODY_LEN);
    localparam logic [15:0] HOLDOFF_CNT = 16'(HOLDOFF);

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  tag_q;
    logic [15:0] data_q;
    logic [15:0] gap_cnt;
    logic        done_q;
    logic [7:0]  tx_byte;
    logic [3:0][7:0] digit;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        nibble_to_ascii u_digit (
            .nibble(data_q[15 - 4*g -: 4]),
            .ascii (digit[g])
        );
    end

`ifdef UART_RPT_CHECKSUM_EN
    logic [7:0] chk;
    logic [7:0] chk_hi;
    logic [7:0] chk_lo;

    assign chk = tag_q ^ COLON ^ digit[0] ^ digit[1] ^ digit[2] ^ digit[3];

    nibble_to_ascii u_chk_hi (.nibble(chk[7:4]), .ascii(chk_hi));
    nibble_to_ascii u_chk_lo (.nibble(chk[3:0]), .ascii(chk_lo));
`endif

    always_comb begin
        tx_byte = 8'h00;
        if (state == SEND) begin
            if (idx == 4'd0)
                tx_byte = tag_q;
            else if (idx == 4'd1)
                tx_byte = COLON;
            else if (idx < 4'd6)
                tx_byte = digit[2'(idx - 4'd2)];
`ifdef UART_RPT_CHECKSUM_EN
            else if (idx == 4'd6)
                tx_byte = chk_hi;
            else if (idx == 4'd7)
                tx_byte = chk_lo;
`endif
            else if ((EOL_CRLF != 0) && (idx == EOL_IDX))
                tx_byte = CR;
            else
                tx_byte = LF;
        end
    end

    // GAP lasts exactly HOLDOFF cycles; requests are only accepted once back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 4'd0;
            tag_q   <= 8'h00;
            data_q  <= 16'h0000;
            gap_cnt <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        tag_q  <= i_tag;
                        data_q <= i_data;
                        idx    <= 4'd0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (!i_tx_full) begin
                        if (idx == LAST_IDX) begin
                            done_q <= 1'b1;
                            idx    <= 4'd0;
                            if (HOLDOFF > 0) begin
                                gap_cnt <= HOLDOFF_CNT;
                                state   <= GAP;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt <= 16'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_tx_push = (state == SEND) && !i_tx_full;
    assign o_tx_data = tx_byte;
    assign o_busy    = (state != IDLE);
    assign o_done    = done_q;

endmodule

// File: tb/tb_uart_report_tx.sv
// Directed bench for uart_report_tx: a CRLF/no-holdoff instance and an LF-only/HOLDOFF=5 instance.
module tb_uart_report_tx;

    localparam int HOLD_B = 5;
`ifdef UART_RPT_CHECKSUM_EN
    localparam int CHK_N = 2;
`else
    localparam int CHK_N = 0;
`endif
    localparam int LEN_A = 8 + CHK_N;
    localparam int LEN_B = 7 + CHK_N;

    logic clk = 1'b0;
    logic rst;
    logic req_a, full_a, push_a, busy_a, done_a;
    logic [7:0] tag_a, txd_a;
    logic [15:0] data_a;
    logic req_b, full_b, push_b, busy_b, done_b;
    logic [7:0] tag_b, txd_b;
    logic [15:0] data_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int idle_data_err = 0;
    int full_push_err = 0;

    logic [7:0] push_q_a[$];
    int push_cyc_a[$];
    int done_cyc_a[$];
    logic busy_at_done_a[$];
    logic [7:0] push_q_b[$];
    int push_cyc_b[$];
    int done_cyc_b[$];
    logic [7:0] exp_frame[$];

    uart_report_tx dut_a (
        .clk(clk), .rst(rst), .i_req(req_a), .i_tag(tag_a), .i_data(data_a),
        .i_tx_full(full_a), .o_tx_data(txd_a), .o_tx_push(push_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    uart_report_tx #(.EOL_CRLF(0), .HOLDOFF(HOLD_B)) dut_b (
        .clk(clk), .rst(rst), .i_req(req_b), .i_tag(tag_b), .i_data(data_b),
        .i_tx_full(full_b), .o_tx_data(txd_b), .o_tx_push(push_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every push and done pulse on the falling edge, tagged with the cycle number.
    always @(negedge clk) begin
        if (!rst) begin
            if (push_a) begin
                push_q_a.push_back(txd_a);
                push_cyc_a.push_back(cyc);
            end
            if (done_a) begin
                done_cyc_a.push_back(cyc);
                busy_at_done_a.push_back(busy_a);
            end
            if (push_b) begin
                push_q_b.push_back(txd_b);
                push_cyc_b.push_back(cyc);
            end
            if (done_b) done_cyc_b.push_back(cyc);
            if ((!busy_a && txd_a != 8'h00) || (!busy_b && txd_b != 8'h00)) idle_data_err++;
            if ((push_a && full_a) || (push_b && full_b)) full_push_err++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic req, input logic [7:0] tag,
                                 input logic [15:0] data, input logic full);
        if (sel == 0) begin
            req_a = req; tag_a = tag; data_a = data; full_a = full;
        end else begin
            req_b = req; tag_b = tag; data_b = data; full_b = full;
        end
    endtask

    task automatic clearQueues();
        push_q_a.delete(); push_cyc_a.delete(); done_cyc_a.delete(); busy_at_done_a.delete();
        push_q_b.delete(); push_cyc_b.delete(); done_cyc_b.delete();
        exp_frame.delete();
    endtask

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Appends the expected frame for one request to exp_frame.
    task automatic buildFrame(input logic [7:0] tag, input logic [15:0] d, input bit crlf);
        logic [7:0] chk;
        logic [7:0] dig;
        exp_frame.push_back(tag);
        exp_frame.push_back(8'h3A);
        chk = tag ^ 8'h3A;
        for (int i = 3; i >= 0; i--) begin
            dig = hexChar(d[4*i +: 4]);
            exp_frame.push_back(dig);
            chk = chk ^ dig;
        end
`ifdef UART_RPT_CHECKSUM_EN
        exp_frame.push_back(hexChar(chk[7:4]));
        exp_frame.push_back(hexChar(chk[3:0]));
`endif
        if (crlf) exp_frame.push_back(8'h0D);
        exp_frame.push_back(8'h0A);
    endtask

    task automatic compareFrame(input string name, input logic [7:0] got[$], input int n);
        checkOutput($sformatf("%s_len", name), got.size(), exp_frame.size());
        for (int i = 0; i < n && i < exp_frame.size(); i++)
            checkOutput($sformatf("%s_byte%0d", name, i), (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, exp_frame[i]});
    endtask

    initial begin
        int c;
        rst = 1'b1;
        applyStimulus(0, 1'b0, 8'h00, 16'h0000, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 16'h0000, 1'b0);
        tick(); tick();

        checkOutput("reset_push", push_a, 1'b0);
        checkOutput("reset_data", txd_a, 8'h00);
        checkOutput("reset_busy", busy_a, 1'b0);
        checkOutput("reset_done", done_a, 1'b0);
        rst = 1'b0;
        tick();

        // Basic frame 'W' 0x1234 on the CRLF instance.
        clearQueues();
        buildFrame(8'h57, 16'h1234, 1'b1);
        c = cyc;
        applyStimulus(0, 1'b1, 8'h57, 16'h1234, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 16'h0000, 1'b0);
        checkOutput("s1_busy_sending", busy_a, 1'b1);
        repeat (LEN_A + 6) tick();
        compareFrame("s1", push_q_a, LEN_A);
        checkOutput("s1_first_push_cyc", (push_cyc_a.size() > 0) ? push_cyc_a[0] : -1, c + 1);
        checkOutput("s1_last_push_cyc", (push_cyc_a.size() > 0) ? push_cyc_a[push_cyc_a.size()-1] : -1, c + LEN_A);
        checkOutput("s1_done_count", done_cyc_a.size(), 1);
        checkOutput("s1_done_cyc", (done_cyc_a.size() > 0) ? done_cyc_a[0] : -1, c + LEN_A + 1);
        checkOutput("s1_busy_at_done", (busy_at_done_a.size() > 0) ? busy_at_done_a[0] : 1'bx, 1'b0);

        // LF-only instance: 'S' 0xABCF, then req held with new tag/data gives a second frame after the holdoff.
        clearQueues();
        buildFrame(8'h53, 16'hABCF, 1'b0);
        buildFrame(8'h57, 16'h1234, 1'b0);
        c = cyc;
        applyStimulus(1, 1'b1, 8'h53, 16'hABCF, 1'b0);
        tick();
        applyStimulus(1, 1'b1, 8'h57, 16'h1234, 1'b0);
        repeat (LEN_B + 6) tick();
        applyStimulus(1, 1'b0, 8'h00, 16'h0000, 1'b0);
        repeat (LEN_B + 4) tick();
        compareFrame("s2", push_q_b, 2 * LEN_B);
        checkOutput("s2_done_cyc", (done_cyc_b.size() > 0) ? done_cyc_b[0] : -1, c + LEN_B + 1);
        checkOutput("s2_second_start", (push_cyc_b.size() > LEN_B) ? push_cyc_b[LEN_B] : -1, c + LEN_B + HOLD_B + 2);
        checkOutput("s2_done_count", done_cyc_b.size(), 2);

        // Backpressure for three cycles after the third push.
        clearQueues();
        buildFrame(8'h57, 16'h1234, 1'b1);
        c = cyc;
        applyStimulus(0, 1'b1, 8'h57, 16'h1234, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h57, 16'h1234, 1'b0);
        tick(); tick(); tick();
        applyStimulus(0, 1'b0, 8'h57, 16'h1234, 1'b1);
        tick(); tick(); tick();
        applyStimulus(0, 1'b0, 8'h57, 16'h1234, 1'b0);
        repeat (LEN_A + 4) tick();
        compareFrame("s3", push_q_a, LEN_A);
        checkOutput("s3_resume_cyc", (push_cyc_a.size() > 3) ? push_cyc_a[3] : -1, c + 7);
        checkOutput("s3_done_cyc", (done_cyc_a.size() > 0) ? done_cyc_a[0] : -1, c + LEN_A + 4);

        // Request while busy is dropped; data changes mid-frame are not seen.
        clearQueues();
        buildFrame(8'h57, 16'h1234, 1'b1);
        applyStimulus(0, 1'b1, 8'h57, 16'h1234, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h57, 16'h1234, 1'b0);
        tick(); tick();
        applyStimulus(0, 1'b1, 8'h44, 16'hFFFF, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h44, 16'hFFFF, 1'b0);
        repeat (LEN_A + 8) tick();
        compareFrame("s4", push_q_a, LEN_A);
        checkOutput("s4_done_count", done_cyc_a.size(), 1);

        // Reset after the fourth push aborts the frame immediately.
        clearQueues();
        buildFrame(8'h57, 16'h1234, 1'b1);
        applyStimulus(0, 1'b1, 8'h57, 16'h1234, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 16'h0000, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_push", push_a, 1'b0);
        checkOutput("s5_rst_busy", busy_a, 1'b0);
        checkOutput("s5_rst_data", txd_a, 8'h00);
        checkOutput("s5_rst_done", done_a, 1'b0);
        checkOutput("s5_partial_len", push_q_a.size(), 4);
        checkOutput("s5_partial_b3", (push_q_a.size() > 3) ? push_q_a[3] : 8'hxx, exp_frame[3]);
        tick(); tick();
        rst = 1'b0;
        tick();
        clearQueues();
        buildFrame(8'h55, 16'h0A5F, 1'b1);
        applyStimulus(0, 1'b1, 8'h55, 16'h0A5F, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 16'h0000, 1'b0);
        repeat (LEN_A + 6) tick();
        compareFrame("s5_after", push_q_a, LEN_A);
        checkOutput("s5_done_count", done_cyc_a.size(), 1);

        checkOutput("idle_data_zero", idle_data_err, 0);
        checkOutput("no_push_when_full", full_push_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
